reg_read_port: RTL and testbench
================================

// Module: reg_read_port
// PURPOSE
//  Read side of the KGP-RISC register bank; the bank's registers are write-enabled negedge DFFs.
//  Accepts dual-source read requests (rs, rt) over a valid/ready handshake.
//  Selects both operands from the flattened bank state, forwards a coincident write,
//  and returns the result through a 2-entry response buffer.
//  Sits between the instruction decoder and the ALU operand latches.
// PARAMETERS
//  DATA_W    32  width of each register
//  ADDR_W     5  register address width; the bank holds 2**ADDR_W registers
// PORTS
//  clk          in   1                 single clock; posedge for this block
//  rst          in   1                 synchronous, active-high reset
//  reg_flat     in   DATA_W*2**ADDR_W  bank contents; register i = reg_flat[i*DATA_W +: DATA_W]
//  wr_en        in   1                 bank write enable (same signal the bank's DFFs use)
//  wr_addr      in   ADDR_W            bank write address
//  wr_data      in   DATA_W            bank write data
//  req_valid    in   1                 read request present
//  req_ready    out  1                 block can accept a request
//  req_rs       in   ADDR_W            source address A
//  req_rt       in   ADDR_W            source address B
//  resp_valid   out  1                 head-of-buffer response valid
//  resp_ready   in   1                 consumer takes the head response
//  resp_rs_data out  DATA_W            operand A of head entry
//  resp_rt_data out  DATA_W            operand B of head entry
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high on clk/rst.
//  - Reset: count=0, rd_ptr=wr_ptr=0, resp_valid=0, resp_*_data=0, req_ready=1 on the following cycle.
//  - Accept: the request is accepted at a posedge where req_valid && req_ready.
//  - Pop: the head entry is popped at a posedge where resp_valid && resp_ready.
//  - req_ready = (count < 2) || pop this cycle. A full buffer that pops in the same cycle can accept.
//  - Operand select for each source, evaluated at the accepting edge:
//      - addr==0 -> 0 (r0 is hardwired zero, with no bypass);
//      - else bypass hit -> wr_data;
//      - else reg_flat slice.
//  - Latency: a response is captured on the accepting edge. resp_valid rises in the next cycle
//    if the buffer was empty. No combinational path from req_* to resp_*.
//  - Buffer: 2 entries, circular, 1-bit pointers that wrap 1 -> 0.
//    count is 0..2 and never exceeds 2. Accept and pop in the same edge leave count unchanged.
//  - resp_*_data always shows entry[rd_ptr]. Its value is don't-care when resp_valid=0 (0 after reset).
//  - Entries are held stable while resp_valid && !resp_ready.
//  - A later bank write does not alter an already-buffered operand (snapshot semantics).
//  - Reset asserted mid-operation: all buffered entries are discarded and the reset values apply.
//    A request presented in the reset cycle is dropped.
// CONFIGURATION
//  REG_BYPASS_EN defined:
//    - bypass hit = wr_en && wr_addr==src && src!=0.
//    - Covers the half cycle before the bank's negedge write lands.
//  REG_BYPASS_EN undefined:
//    - no bypass hit; operands always come from reg_flat (or 0 for r0).
//    - wr_* inputs are unused.
// STRUCTURE
//  - Shared package kgp_risc_pkg holds: DATA_W and ADDR_W defaults, REG_ZERO=0,
//    and the resp_entry_t typedef {rs_data, rt_data}.
//  - Sub-module reg_operand_sel: purely combinational. It is instantiated twice (rs, rt).
//    Inputs are reg_flat, addr and wr_*; output is the selected operand.
//  - Top level holds the buffer, pointers, count and handshake logic.
// TESTING
//  1. Reset: rst=1 for 2 cycles, req_valid=1 -> no accept; after release resp_valid=0,
//     resp data=0, req_ready=1.
//  2. Plain read: r3=0x1234, r7=0xDEAD, req rs=3 rt=7, resp_ready=1
//     -> next cycle resp=0x1234/0xDEAD, resp_valid high for 1 cycle.
//  3. r0 and bypass: wr_en=1 wr_addr=5 wr_data=0xCAFE, reg_flat r5=0x1111, req rs=5 rt=0
//     -> with REG_BYPASS_EN 0xCAFE/0; without it 0x1111/0. Also wr_addr=0 wr_data=0xFFFF, req rs=0 -> 0.
//  4. Backpressure and full: resp_ready=0, three back-to-back requests
//     -> first two accepted, req_ready=0 on the third, resp holds the first entry.
//     Then resp_ready=1 with the third still asserted -> pop and accept on the same edge, count stays 2.
//  5. Wrap and order: 6 requests rs=1..6 with resp_ready toggling 1,0,1,...
//     -> responses return in order 1..6 with no loss or duplication, and pointers wrap correctly.
//  6. Reset mid-operation: buffer full, assert rst for 1 cycle
//     -> resp_valid=0, count=0; the next request's response is fresh data, not stale entries.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : kgp_risc_pkg
// Description : Shared definitions for the KGP-RISC register bank read side:
//               default bank geometry, the hardwired-zero register index and
//               the response-buffer entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package kgp_risc_pkg;

    // Default bank geometry: 32 registers of 32 bits.
    localparam int KGP_DATA_W = 32;
    localparam int KGP_ADDR_W = 5;

    // Register r0 always reads as zero.
    localparam int REG_ZERO = 0;

    // One buffered read response: both operands captured together.
    typedef struct packed {
        logic [KGP_DATA_W-1:0] rs_data;
        logic [KGP_DATA_W-1:0] rt_data;
    } resp_entry_t;

endpackage : kgp_risc_pkg
`default_nettype wire

// File: rtl/reg_operand_sel.sv
`default_nettype none
// ============================================================================
// Module      : reg_operand_sel
// Description : Purely combinational operand selector for one read source.
//               Priority: r0 -> 0, then write bypass (optional), then the
//               bank word addressed by addr.
// Config      : REG_BYPASS_EN - when defined, a write in flight to the same
//               (non-zero) register is forwarded; when undefined the wr_*
//               inputs are ignored.
// Ports       : reg_flat - flattened bank contents
//               addr     - source register address
//               wr_en / wr_addr / wr_data - bank write port (bypass source)
//               operand  - selected operand
// Revision    : 1.0 - initial release
// ============================================================================
module reg_operand_sel
    import kgp_risc_pkg::*;
#(
    parameter int DATA_W = KGP_DATA_W,
    parameter int ADDR_W = KGP_ADDR_W
) (
    input  logic [DATA_W*(2**ADDR_W)-1:0] reg_flat,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             operand
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0] w_bank_word;
    logic              w_is_zero;
    logic              w_bypass_hit;

    assign w_is_zero = (addr == ADDR_W'(REG_ZERO));

    // Plain read mux over the flattened bank.
    always_comb begin
        w_bank_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                w_bank_word = reg_flat[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef REG_BYPASS_EN
    // The bank latches on the falling edge, so during the high half of the
    // cycle reg_flat still holds the old value; forward the pending write.
    assign w_bypass_hit = wr_en && (wr_addr == addr) && !w_is_zero;
`else
    assign w_bypass_hit = 1'b0;

    logic w_unused_wr;
    assign w_unused_wr = &{1'b0, wr_en, wr_addr, wr_data};
`endif

    always_comb begin
        operand = w_bank_word;
        if (w_is_zero) begin
            operand = '0;
        end else if (w_bypass_hit) begin
            operand = wr_data;
        end
    end

endmodule : reg_operand_sel
`default_nettype wire

// File: rtl/reg_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_port
// Description : Read side of the KGP-RISC register bank. Accepts dual-source
//               (rs, rt) read requests over valid/ready, selects both
//               operands from the bank (with optional write forwarding) and
//               returns them through a 2-entry circular response buffer.
// Config      : REG_BYPASS_EN - enables forwarding of a coincident bank
//               write to the operand selectors.
// Ports       : clk, rst            - clock (posedge), sync active-high reset
//               reg_flat            - flattened bank contents
//               wr_en/wr_addr/wr_data - bank write port (bypass source)
//               req_valid/req_ready - request handshake
//               req_rs/req_rt       - source register addresses
//               resp_valid/resp_ready - response handshake
//               resp_rs_data/resp_rt_data - head-of-buffer operands
// Revision    : 1.0 - initial release
// ============================================================================
module reg_read_port
    import kgp_risc_pkg::*;
#(
    parameter int DATA_W = KGP_DATA_W,
    parameter int ADDR_W = KGP_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W*(2**ADDR_W)-1:0] reg_flat,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_rs,
    input  logic [ADDR_W-1:0]             req_rt,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_W-1:0]             resp_rs_data,
    output logic [DATA_W-1:0]             resp_rt_data
);

    localparam logic [1:0] C_DEPTH = 2'd2;

    // Response storage and bookkeeping
    resp_entry_t r_entry [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic              w_accept;
    logic              w_pop;
    logic [DATA_W-1:0] w_rs_op;
    logic [DATA_W-1:0] w_rt_op;

    // ------------------------------------------------------------------
    // Operand selection (one selector per source)
    // ------------------------------------------------------------------
    reg_operand_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs_sel (
        .reg_flat (reg_flat),
        .addr     (req_rs),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .operand  (w_rs_op)
    );

    reg_operand_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rt_sel (
        .reg_flat (reg_flat),
        .addr     (req_rt),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .operand  (w_rt_op)
    );

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign resp_valid = (r_count != 2'd0);
    assign w_pop      = resp_valid && resp_ready;
    // A full buffer can still take a request when its head leaves this edge.
    assign req_ready  = (r_count < C_DEPTH) || w_pop;
    assign w_accept   = req_valid && req_ready;

    // Outputs come straight from storage, so req_* never reaches resp_*
    // combinationally.
    assign resp_rs_data = r_entry[r_rd_ptr].rs_data;
    assign resp_rt_data = r_entry[r_rd_ptr].rt_data;

    // ------------------------------------------------------------------
    // Buffer, pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            // When full with a simultaneous pop, wr_ptr equals rd_ptr: the
            // departing head slot is reused for the incoming entry.
            if (w_accept) begin
                r_entry[r_wr_ptr].rs_data <= w_rs_op;
                r_entry[r_wr_ptr].rt_data <= w_rt_op;
                r_wr_ptr                  <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : reg_read_port
`default_nettype wire

// File: tb/tb_reg_read_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_read_port
// Description : Self-checking bench for reg_read_port. A queue-based model of
//               the response buffer predicts every handshake and operand;
//               table vectors, directed corner sequences and a randomized
//               phase drive the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_read_port;
    import kgp_risc_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

`ifdef REG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DW*NR-1:0]  reg_flat;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_rs;
    logic [AW-1:0]     req_rt;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_rs_data;
    logic [DW-1:0]     resp_rt_data;

    logic [DW-1:0]     regs [NR];

    always #5 clk = ~clk;

    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < NR; i++) reg_flat[i*DW +: DW] = regs[i];
    end

    reg_read_port #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_flat     (reg_flat),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rs       (req_rs),
        .req_rt       (req_rt),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rs_data (resp_rs_data),
        .resp_rt_data (resp_rt_data)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    pair_t mq[$];
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic logic [DW-1:0] ref_op(input logic [AW-1:0] addr);
        if (addr == 0) return '0;
        if (BYP && wr_en && (wr_addr == addr)) return wr_data;
        return regs[addr];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("resp_valid", {63'd0, resp_valid}, {63'd0, mq.size() != 0});
        chk("req_ready", {63'd0, req_ready},
            {63'd0, (mq.size() < 2) || (mq.size() != 0 && resp_ready)});
        if (mq.size() != 0) begin
            chk("resp_rs_data", resp_rs_data, mq[0].a);
            chk("resp_rt_data", resp_rt_data, mq[0].b);
        end
    endtask

    // Inputs are set after a posedge; outputs are compared just after the
    // following negedge, then the model advances on the posedge.
    task automatic step(input bit do_check, output bit acc, output bit pop);
        pair_t e;
        @(negedge clk);
        #1;
        if (do_check) check_outputs();
        @(posedge clk);
        acc = 1'b0;
        pop = 1'b0;
        if (rst) begin
            mq.delete();
        end else begin
            pop   = (mq.size() != 0) && resp_ready;
            acc   = req_valid && ((mq.size() < 2) || pop);
            e.a   = ref_op(req_rs);
            e.b   = ref_op(req_rt);
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        #1;
    endtask

    task automatic tick();
        bit a, p;
        step(1'b1, a, p);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          wen;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] ers;
        logic [DW-1:0] ert;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            acc, pop;
        logic [DW-1:0] got [$];
        logic [DW-1:0] old4;
        int            sent, cyc;

        for (int i = 0; i < NR; i++) regs[i] = 32'hA000_0000 | i;
        regs[3] = 32'h0000_1234;
        regs[7] = 32'h0000_DEAD;
        regs[5] = 32'h0000_1111;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b1; req_rs = 5'd3; req_rt = 5'd7; resp_ready = 1'b1;

        // ---- reset with a request present: nothing accepted ----
        step(1'b0, acc, pop);
        step(1'b0, acc, pop);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_rs_data", resp_rs_data, 64'd0);
        chk("rst_rt_data", resp_rt_data, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        rst = 1'b0; req_valid = 1'b0;
        tick();
        chk("rst_dropped", {63'd0, resp_valid}, 64'd0);

        // ---- table: plain reads, r0, bypass ----
        vt[0] = '{5'd3,  5'd7, 1'b0, 5'd0, 32'h0,      32'h1234,     32'hDEAD};
        vt[1] = '{5'd5,  5'd0, 1'b1, 5'd5, 32'hCAFE,   BYP ? 32'hCAFE : 32'h1111, 32'h0};
        vt[2] = '{5'd0,  5'd0, 1'b1, 5'd0, 32'hFFFF,   32'h0,        32'h0};
        vt[3] = '{5'd7,  5'd3, 1'b1, 5'd9, 32'h5555,   32'hDEAD,     32'h1234};
        vt[4] = '{5'd5,  5'd5, 1'b0, 5'd5, 32'hBEEF,   32'h1111,     32'h1111};
        vt[5] = '{5'd31, 5'd1, 1'b1, 5'd1, 32'h77,     32'hA000_001F, BYP ? 32'h77 : 32'hA000_0001};
        for (int v = 0; v < 6; v++) begin
            req_valid = 1'b1; req_rs = vt[v].rs; req_rt = vt[v].rt;
            wr_en = vt[v].wen; wr_addr = vt[v].wa; wr_data = vt[v].wd;
            resp_ready = 1'b1;
            tick();
            req_valid = 1'b0; wr_en = 1'b0;
            #1;
            chk($sformatf("tbl%0d_valid", v), {63'd0, resp_valid}, 64'd1);
            chk($sformatf("tbl%0d_rs", v), resp_rs_data, vt[v].ers);
            chk($sformatf("tbl%0d_rt", v), resp_rt_data, vt[v].ert);
            tick();
            chk($sformatf("tbl%0d_one_cycle", v), {63'd0, resp_valid}, 64'd0);
        end

        // ---- backpressure and full ----
        resp_ready = 1'b0; req_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            req_rs = AW'(k); req_rt = AW'(k + 10);
            #1;
            if (k == 3) begin
                chk("full_req_ready", {63'd0, req_ready}, 64'd0);
                chk("full_head_rs", resp_rs_data, regs[1]);
            end
            tick();
        end
        chk("full_hold_rs", resp_rs_data, regs[1]);
        chk("full_hold_rt", resp_rt_data, regs[11]);
        resp_ready = 1'b1;
        #1;
        chk("full_pop_ready", {63'd0, req_ready}, 64'd1);
        tick();
        resp_ready = 1'b0; req_valid = 1'b0;
        #1;
        chk("full_count_two", {63'd0, req_ready}, 64'd0);
        chk("full_new_head", resp_rs_data, regs[2]);
        resp_ready = 1'b1;
        repeat (3) tick();

        // ---- wrap and order ----
        got.delete();
        sent = 1; cyc = 0;
        req_valid = 1'b1; req_rs = 5'd1; req_rt = 5'd0; resp_ready = 1'b1;
        while ((sent <= 6 || mq.size() != 0) && cyc < 100) begin
            #1;
            if (resp_valid && resp_ready) got.push_back(resp_rs_data);
            step(1'b1, acc, pop);
            if (acc) sent++;
            req_valid  = (sent <= 6);
            req_rs     = AW'(sent);
            resp_ready = ~resp_ready;
            cyc++;
        end
        chk("order_budget", {63'd0, cyc < 100}, 64'd1);
        chk("order_count", got.size(), 64'd6);
        for (int i = 0; i < got.size() && i < 6; i++)
            chk($sformatf("order_%0d", i), got[i], regs[i + 1]);
        req_valid = 1'b0; resp_ready = 1'b1;
        repeat (2) tick();

        // ---- snapshot: later bank change/write does not alter entry ----
        old4 = regs[4];
        resp_ready = 1'b0; req_valid = 1'b1; req_rs = 5'd4; req_rt = 5'd4;
        tick();
        req_valid = 1'b0;
        regs[4] = 32'h5A5A_5A5A; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0BAD;
        repeat (2) tick();
        chk("snapshot_rs", resp_rs_data, old4);
        wr_en = 1'b0; resp_ready = 1'b1;
        repeat (2) tick();

        // ---- reset mid-operation ----
        resp_ready = 1'b0; req_valid = 1'b1;
        req_rs = 5'd2; tick();
        req_rs = 5'd4; tick();
        rst = 1'b1; req_rs = 5'd6;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_ready", {63'd0, req_ready}, 64'd1);
        chk("midrst_rs_data", resp_rs_data, 64'd0);
        regs[9] = 32'h9999_0009;
        req_valid = 1'b1; req_rs = 5'd9; req_rt = 5'd2; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        #1;
        chk("midrst_fresh_rs", resp_rs_data, 32'h9999_0009);
        chk("midrst_fresh_rt", resp_rt_data, regs[2]);
        chk("midrst_one_entry", {63'd0, resp_valid}, 64'd1);
        tick();

        // ---- randomized phase ----
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 39) == 0);
            req_valid  = $urandom_range(0, 1) == 1;
            req_rs     = AW'($urandom);
            req_rt     = AW'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = ($urandom_range(0, 2) == 0) ? req_rs : AW'($urandom);
            wr_data    = $urandom;
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NR - 1)] = $urandom;
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_reg_read_port
`default_nettype wire
